// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller and the ball/paddle game engine.
// Holds the controller state codes, serve directions and the score/period widths.
package pong_pkg;

  localparam int unsigned ScoreW  = 4;
  localparam int unsigned PeriodW = 17;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StDelay = 3'd1;
  localparam state_t StPlay  = 3'd2;
  localparam state_t StPoint = 3'd3;
  localparam state_t StOver  = 3'd4;

  localparam logic DIR_A = 1'b0;
  localparam logic DIR_B = 1'b1;

endpackage

// File: rtl/pong_ball_speed.sv
// Ball step period tracker: restarts at the base period for every serve and
// shortens by a fixed step after each group of paddle hits, never going below the floor.
module pong_ball_speed
  import pong_pkg::*;
#(
  parameter int unsigned BASE_BALL_PERIOD = 91071,
  parameter int unsigned MIN_BALL_PERIOD  = 30000,
  parameter int unsigned SPEED_STEP       = 4096,
  parameter int unsigned HITS_PER_STEP    = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_base_i,
  input  logic               hit_i,
  output logic [PeriodW-1:0] period_o
);

  localparam int unsigned HitW = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;

  localparam logic [PeriodW-1:0] BaseP = PeriodW'(BASE_BALL_PERIOD);
  localparam logic [PeriodW-1:0] MinP  = PeriodW'(MIN_BALL_PERIOD);
  localparam logic [PeriodW-1:0] StepP = PeriodW'(SPEED_STEP);
  localparam logic [HitW-1:0]    LastHit = HitW'(HITS_PER_STEP - 1);

  logic [HitW-1:0]    hits_q, hits_d;
  logic [PeriodW-1:0] period_q, period_d;
  logic [PeriodW-1:0] headroom;

  always_comb begin
    hits_d   = hits_q;
    period_d = period_q;
    // Only meaningful when period_q > MinP; the compare below guards the underflow case.
    headroom = period_q - MinP;
    if (load_base_i) begin
      hits_d   = '0;
      period_d = BaseP;
    end else if (hit_i) begin
      if (hits_q == LastHit) begin
        hits_d   = '0;
        period_d = ((period_q > MinP) && (headroom > StepP)) ? (period_q - StepP) : MinP;
      end else begin
        hits_d = hits_q + HitW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hits_q   <= '0;
      period_q <= BaseP;
    end else begin
      hits_q   <= hits_d;
      period_q <= period_d;
    end
  end

  assign period_o = period_q;

endmodule

// File: rtl/pong_match_controller.sv
// Pong match sequencer: attract, serve delay, rally, point scoring and game over.
// Drives the engine's ball enable, serve strobe/direction and ball step period.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE          = 11,
  parameter int unsigned SERVE_DELAY_CYCLES = 67108864,
  parameter int unsigned BASE_BALL_PERIOD   = 91071,
  parameter int unsigned MIN_BALL_PERIOD    = 30000,
  parameter int unsigned SPEED_STEP         = 4096,
  parameter int unsigned HITS_PER_STEP      = 4
) (
  input  logic               SYSTEM_CLOCK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic               HIT_A,
  input  logic               HIT_B,
  input  logic               MISS_A,
  input  logic               MISS_B,
  output logic               BALL_ENABLE,
  output logic               SERVE,
  output logic               SERVE_DIR,
  output logic [PeriodW-1:0] BALL_PERIOD,
  output logic [ScoreW-1:0]  SCORE_A,
  output logic [ScoreW-1:0]  SCORE_B,
  output logic               GAME_OVER,
  output logic               WINNER,
  output logic [2:0]         STATE
);

  localparam int unsigned CntW = (SERVE_DELAY_CYCLES > 1) ? $clog2(SERVE_DELAY_CYCLES) : 1;

  localparam logic [CntW-1:0]   DelayLoad = CntW'(SERVE_DELAY_CYCLES - 1);
  localparam logic [ScoreW-1:0] WinS      = ScoreW'(WIN_SCORE);

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ScoreW-1:0] score_a_q, score_a_d, score_b_q, score_b_d;
  logic              dir_q, dir_d;
  logic              winner_q, winner_d;
  logic              serve_q, serve_d;
  logic              start_q;
  logic              start_rise;
  logic              load_base;
  logic              rally_hit;

  assign start_rise = START & ~start_q;
  assign load_base  = (state_q == StDelay) && (cnt_q == '0);
  // A miss in the same cycle wins over the hit.
  assign rally_hit  = (state_q == StPlay) && (HIT_A | HIT_B) && !(MISS_A | MISS_B);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    dir_d     = dir_q;
    winner_d  = winner_q;
    serve_d   = 1'b0;
    unique case (state_q)
      StIdle, StOver: begin
        if (start_rise) begin
          score_a_d = '0;
          score_b_d = '0;
          dir_d     = DIR_B;
          cnt_d     = DelayLoad;
          state_d   = StDelay;
        end
      end
      StDelay: begin
        if (cnt_q == '0) begin
          serve_d = 1'b1;
          state_d = StPlay;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPlay: begin
        if (MISS_A) begin
          score_b_d = score_b_q + ScoreW'(1);
          dir_d     = DIR_A;
          state_d   = StPoint;
        end else if (MISS_B) begin
          score_a_d = score_a_q + ScoreW'(1);
          dir_d     = DIR_B;
          state_d   = StPoint;
        end
      end
      StPoint: begin
        if (score_a_q == WinS) begin
          winner_d = DIR_A;
          state_d  = StOver;
        end else if (score_b_q == WinS) begin
          winner_d = DIR_B;
          state_d  = StOver;
        end else begin
          cnt_d   = DelayLoad;
          state_d = StDelay;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge SYSTEM_CLOCK) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      score_a_q <= '0;
      score_b_q <= '0;
      dir_q     <= 1'b0;
      winner_q  <= 1'b0;
      serve_q   <= 1'b0;
      start_q   <= 1'b1;  // a button held through reset must not start a match
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      dir_q     <= dir_d;
      winner_q  <= winner_d;
      serve_q   <= serve_d;
      start_q   <= START;
    end
  end

  pong_ball_speed #(
    .BASE_BALL_PERIOD (BASE_BALL_PERIOD),
    .MIN_BALL_PERIOD  (MIN_BALL_PERIOD),
    .SPEED_STEP       (SPEED_STEP),
    .HITS_PER_STEP    (HITS_PER_STEP)
  ) u_ball_speed (
    .clk_i       (SYSTEM_CLOCK),
    .rst_ni      (RESET_N),
    .load_base_i (load_base),
    .hit_i       (rally_hit),
    .period_o    (BALL_PERIOD)
  );

  // The serve cycle recentres the ball, so the engine is released one cycle later.
  assign BALL_ENABLE = (state_q == StPlay) && !serve_q;
  assign SERVE       = serve_q;
  assign SERVE_DIR   = dir_q;
  assign SCORE_A     = score_a_q;
  assign SCORE_B     = score_b_q;
  assign GAME_OVER   = (state_q == StOver);
  assign WINNER      = winner_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Bench for pong_match_controller: directed match scenarios plus random play,
// compared every cycle against a timestamp-based model of the match rules.
module tb_pong_match_controller;

  localparam int unsigned WIN  = 3;
  localparam int unsigned D    = 8;
  localparam int unsigned BASE = 100;
  localparam int unsigned MINP = 70;
  localparam int unsigned STEP = 20;
  localparam int unsigned HPS  = 2;

  logic        clk = 1'b0;
  logic        rst_n, start, hit_a, hit_b, miss_a, miss_b;
  logic        ball_en, serve, serve_dir, game_over, winner;
  logic [16:0] ball_period;
  logic [3:0]  score_a, score_b;
  logic [2:0]  state;

  always #5 clk = ~clk;

  pong_match_controller #(
    .WIN_SCORE          (WIN),
    .SERVE_DELAY_CYCLES (D),
    .BASE_BALL_PERIOD   (BASE),
    .MIN_BALL_PERIOD    (MINP),
    .SPEED_STEP         (STEP),
    .HITS_PER_STEP      (HPS)
  ) dut (
    .SYSTEM_CLOCK (clk),
    .RESET_N      (rst_n),
    .START        (start),
    .HIT_A        (hit_a),
    .HIT_B        (hit_b),
    .MISS_A       (miss_a),
    .MISS_B       (miss_b),
    .BALL_ENABLE  (ball_en),
    .SERVE        (serve),
    .SERVE_DIR    (serve_dir),
    .BALL_PERIOD  (ball_period),
    .SCORE_A      (score_a),
    .SCORE_B      (score_b),
    .GAME_OVER    (game_over),
    .WINNER       (winner),
    .STATE        (state)
  );

  int n_pass  = 0;
  int n_total = 0;
  int serves_seen = 0;

  // Model: absolute cycle numbers of the next serve and of the pending point decision.
  longint cyc = 0;
  longint m_serve_cyc, m_point_cyc;
  bit     m_rally, m_over, m_dir, m_winner, m_prev_start;
  int     m_sa, m_sb, m_period, m_hits;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_step();
    bit rise, waiting;
    longint c = cyc;
    if (!rst_n) begin
      m_serve_cyc = -1; m_point_cyc = -1;
      m_rally = 0; m_over = 0; m_dir = 0; m_winner = 0; m_prev_start = 1;
      m_sa = 0; m_sb = 0; m_period = BASE; m_hits = 0;
    end else begin
      rise    = start && !m_prev_start;
      waiting = m_serve_cyc > c;
      if (m_rally) begin
        if (miss_a) begin
          m_sb++; m_dir = 0; m_rally = 0; m_point_cyc = c + 1;
        end else if (miss_b) begin
          m_sa++; m_dir = 1; m_rally = 0; m_point_cyc = c + 1;
        end else if (hit_a || hit_b) begin
          m_hits++;
          if (m_hits == HPS) begin
            m_hits = 0;
            m_period = (m_period - int'(STEP) < int'(MINP)) ? MINP : m_period - STEP;
          end
        end
      end else if (c == m_point_cyc) begin
        if (m_sa == WIN) begin m_over = 1; m_winner = 0; end
        else if (m_sb == WIN) begin m_over = 1; m_winner = 1; end
        else m_serve_cyc = c + D + 1;
      end else if (!waiting && rise) begin
        m_sa = 0; m_sb = 0; m_dir = 1; m_over = 0; m_serve_cyc = c + D + 1;
      end
      if (c + 1 == m_serve_cyc) begin
        m_rally = 1; m_period = BASE; m_hits = 0;
      end
      m_prev_start = start;
    end
  endtask

  task automatic compare_all();
    int  exp_state;
    bit  exp_serve;
    exp_serve = (cyc == m_serve_cyc);
    exp_state = m_over ? 4 : m_rally ? 2 : (cyc == m_point_cyc) ? 3 : (m_serve_cyc > cyc) ? 1 : 0;
    if (serve === 1'b1) serves_seen++;
    check("STATE", state, exp_state);
    check("SERVE", serve, exp_serve);
    check("BALL_ENABLE", ball_en, m_rally && !exp_serve);
    check("SERVE_DIR", serve_dir, m_dir);
    check("BALL_PERIOD", ball_period, m_period);
    check("SCORE_A", score_a, m_sa);
    check("SCORE_B", score_b, m_sb);
    check("GAME_OVER", game_over, m_over);
    if (m_over) check("WINNER", winner, m_winner);
  endtask

  task automatic tick(input bit ha, input bit hb, input bit ma, input bit mb);
    hit_a = ha; hit_b = hb; miss_a = ma; miss_b = mb;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  // Returns the number of ticks taken until SERVE is seen (bounded).
  task automatic wait_serve(output int n);
    n = 0;
    while (serve !== 1'b1 && n < 40) begin
      tick(0, 0, 0, 0);
      n++;
    end
    if (n >= 40) check("serve timeout", 0, 1);
  endtask

  int n;

  initial begin
    rst_n = 0; start = 1;
    hit_a = 0; hit_b = 0; miss_a = 0; miss_b = 0;
    @(negedge clk);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    rst_n = 1;
    repeat (4) tick(0, 0, 0, 0);
    check("held START no start", state, 0);
    check("held START no serve", serves_seen, 0);
    check("reset period", ball_period, 100);

    start = 0; tick(0, 0, 0, 0);
    start = 1; tick(0, 0, 0, 0);
    wait_serve(n);
    check("first serve latency", n + 1, 9);
    check("first serve dir", serve_dir, 1);
    check("ball low in serve cycle", ball_en, 0);
    tick(0, 0, 0, 0);
    check("ball enabled after serve", ball_en, 1);

    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(1, 0, 0, 0);
    check("period after 2 hits", ball_period, 80);
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    check("period saturates", ball_period, 70);
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    check("period stays at floor", ball_period, 70);
    tick(0, 0, 1, 0);
    check("miss A scores B", score_b, 1);
    check("miss A dir", serve_dir, 0);
    wait_serve(n);
    check("period reset on serve", ball_period, 100);
    tick(0, 0, 0, 0);

    tick(0, 0, 0, 1);
    check("miss B scores A", score_a, 1);
    wait_serve(n);
    check("serve dir after miss B", serve_dir, 1);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 1);
    check("double miss B score", score_b, 2);
    check("double miss A score", score_a, 1);
    check("double miss dir", serve_dir, 0);
    wait_serve(n); tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    wait_serve(n); tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    check("game over", game_over, 1);
    check("winner A", winner, 0);
    check("final score A", score_a, 3);
    check("ball off in over", ball_en, 0);
    tick(1, 1, 1, 1); tick(0, 0, 1, 0);
    check("over holds A", score_a, 3);
    check("over holds B", score_b, 2);
    start = 0; tick(0, 0, 0, 0);
    start = 1; tick(0, 0, 0, 0);
    check("rematch clears A", score_a, 0);
    check("rematch clears B", score_b, 0);
    wait_serve(n);
    check("rematch serve latency", n + 1, 9);
    tick(0, 0, 0, 0);

    tick(0, 1, 0, 1);
    check("hit+miss scores", score_a, 1);
    wait_serve(n); tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("hit ignored with miss", ball_period, 100);
    tick(1, 0, 0, 0);
    check("second hit speeds up", ball_period, 80);

    tick(0, 0, 1, 0);
    repeat (5) tick(0, 0, 0, 0);
    check("in delay before reset", state, 1);
    rst_n = 0; tick(0, 0, 0, 0);
    rst_n = 1;
    serves_seen = 0;
    repeat (20) tick(0, 0, 0, 0);
    check("no serve after abort", serves_seen, 0);
    check("abort state idle", state, 0);
    check("abort period", ball_period, 100);
    check("abort score A", score_a, 0);
    check("abort dir", serve_dir, 0);

    repeat (4000) begin
      rst_n = ($urandom_range(999) != 0);
      if ($urandom_range(49) == 0) start = ~start;
      tick($urandom_range(9) == 0, $urandom_range(9) == 0,
           $urandom_range(29) == 0, $urandom_range(29) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
